// File: rtl/ultrasonic_pkg.sv
// Shared types, default timings and the echo-width rule for the ultrasonic echo emulator.
package ultrasonic_pkg;

  localparam int unsigned CYC_PER_CM_DEF   = 5831;
  localparam int unsigned TRIG_MIN_CYC_DEF = 1000;
  localparam int unsigned BURST_CYC_DEF    = 20000;
  localparam int unsigned MAX_CM_DEF       = 400;
  localparam int unsigned MAX_ECHO_CYC_DEF = 3800000;
  localparam int unsigned HOLDOFF_CYC_DEF  = 6000000;

  localparam int CNT_W  = 23;
  localparam int HI_W   = 16;
  localparam int DIST_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TRIG_HI = 3'd1,
    ST_BURST   = 3'd2,
    ST_ECHO    = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_e;

  // Zero or beyond-range distances report the sensor's "no target" pulse width.
  function automatic logic [CNT_W-1:0] echo_width(input logic [DIST_W-1:0] d,
                                                  input int unsigned cpc,
                                                  input int unsigned max_cm,
                                                  input int unsigned max_echo);
    if (d != '0 && 32'(d) <= max_cm) return CNT_W'(32'(d) * cpc);
    return CNT_W'(max_echo);
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchroniser for a single asynchronous level (trigger input, echo capture).
module bit_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff_q <= '0;
    else        ff_q <= {ff_q[0], d_i};
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/ultrasonic_echo_emulator.sv
// HC-SR04 style target emulator: validates the trigger pulse, waits out the burst,
// then returns an echo whose width encodes the latched distance.
module ultrasonic_echo_emulator
  import ultrasonic_pkg::*;
#(
  parameter int unsigned CYC_PER_CM   = CYC_PER_CM_DEF,
  parameter int unsigned TRIG_MIN_CYC = TRIG_MIN_CYC_DEF,
  parameter int unsigned BURST_CYC    = BURST_CYC_DEF,
  parameter int unsigned MAX_CM       = MAX_CM_DEF,
  parameter int unsigned MAX_ECHO_CYC = MAX_ECHO_CYC_DEF,
  parameter int unsigned HOLDOFF_CYC  = HOLDOFF_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig,
  input  logic [DIST_W-1:0] dist_cm,
  output logic              echo,
  output logic              busy,
  output logic              short_trig,
  output logic              meas_done
);

  // BURST is entered one clock after the fall is seen, so it lasts BURST_CYC-1 clocks.
  localparam logic [CNT_W-1:0] BURST_LOAD = CNT_W'(BURST_CYC - 2);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLDOFF_CYC - 1);

  logic              trig_s;
  logic              trig_prev_q;
  state_e            state_q, state_d;
  logic [HI_W-1:0]   hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DIST_W-1:0] dist_q, dist_d;
  logic              echo_q, echo_d;
  logic              short_q, short_d;
  logic              done_q, done_d;

  bit_sync u_trig_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (trig),
    .q_o   (trig_s)
  );

  always_comb begin
    state_d  = state_q;
    hi_cnt_d = hi_cnt_q;
    cnt_d    = cnt_q;
    dist_d   = dist_q;
    echo_d   = echo_q;
    short_d  = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Edge, not level: a trigger still high from an earlier pulse is ignored.
        if (trig_s && !trig_prev_q) begin
          state_d  = ST_TRIG_HI;
          hi_cnt_d = HI_W'(1);
        end
      end
      ST_TRIG_HI: begin
        if (trig_s) begin
          if (hi_cnt_q != '1) hi_cnt_d = hi_cnt_q + HI_W'(1);
        end else if (32'(hi_cnt_q) >= TRIG_MIN_CYC) begin
          state_d = ST_BURST;
          dist_d  = dist_cm;
          cnt_d   = BURST_LOAD;
        end else begin
          state_d = ST_IDLE;
          short_d = 1'b1;
        end
      end
      ST_BURST: begin
        if (cnt_q == '0) begin
          state_d = ST_ECHO;
          echo_d  = 1'b1;
          cnt_d   = echo_width(dist_q, CYC_PER_CM, MAX_CM, MAX_ECHO_CYC) - CNT_W'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ECHO: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLDOFF;
          echo_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLDOFF: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      trig_prev_q <= 1'b0;
      hi_cnt_q    <= '0;
      cnt_q       <= '0;
      dist_q      <= '0;
      echo_q      <= 1'b0;
      short_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_prev_q <= trig_s;
      hi_cnt_q    <= hi_cnt_d;
      cnt_q       <= cnt_d;
      dist_q      <= dist_d;
      echo_q      <= echo_d;
      short_q     <= short_d;
      done_q      <= done_d;
    end
  end

  assign echo       = echo_q;
  assign short_trig = short_q;
  assign meas_done  = done_q;
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_TRIG_HI);

endmodule

// File: doc/ultrasonic_echo_emulator.md
ULTRASONIC_ECHO_EMULATOR -- requirements
Module: ultrasonic_echo_emulator

Interface
REQ-001 Parameter CYC_PER_CM, default 5831, meaning echo clocks per cm of target distance at 100 MHz (58.31 us/cm).
REQ-002 Parameter TRIG_MIN_CYC, default 1000, meaning minimum valid trigger high time in clocks (10 us).
REQ-003 Parameter BURST_CYC, default 20000, meaning delay from trigger fall to echo rise in clocks (200 us).
REQ-004 Parameter MAX_CM, default 400, meaning largest in-range distance.
REQ-005 Parameter MAX_ECHO_CYC, default 3800000, meaning out-of-range echo width in clocks (38 ms).
REQ-006 Parameter HOLDOFF_CYC, default 6000000, meaning dead time after echo fall before a new trigger is accepted (60 ms).
REQ-007 clk  in  1  system clock, 100 MHz, all logic on rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 trig  in  1  asynchronous trigger from the initiator; synchronised internally.
REQ-010 dist_cm  in  9  simulated target distance in cm, unsigned.
REQ-011 echo  out  1  echo pulse; width encodes distance.
REQ-012 busy  out  1  high in any state other than IDLE and TRIG_HI.
REQ-013 short_trig  out  1  one-clock pulse when a trigger shorter than TRIG_MIN_CYC is rejected.
REQ-014 meas_done  out  1  one-clock pulse in the clock where echo falls.

Function
REQ-015 trig shall pass a 2-flop synchroniser; all edges below refer to the synchronised signal.
REQ-016 FSM states shall be IDLE, TRIG_HI, BURST, ECHO, HOLDOFF.
REQ-017 IDLE: rising trig -> TRIG_HI, high-time counter cleared to 1.
REQ-018 TRIG_HI: counter increments each clock trig is high, saturating at 16 bits; trig held high indefinitely keeps FSM in TRIG_HI.
REQ-019 TRIG_HI on trig fall: count >= TRIG_MIN_CYC -> BURST; else short_trig pulse, -> IDLE.
REQ-020 On BURST entry dist_cm shall be latched; later dist_cm changes shall not affect the current measurement.
REQ-021 Echo width W = latched dist_cm * CYC_PER_CM (23-bit unsigned product) when 1 <= dist_cm <= MAX_CM; otherwise W = MAX_ECHO_CYC.
REQ-022 echo shall rise exactly BURST_CYC clocks after the clock in which the trig fall is detected, and stay high exactly W clocks.
REQ-023 At echo fall: meas_done pulses, FSM -> HOLDOFF; after HOLDOFF_CYC clocks -> IDLE.
REQ-024 Trig edges in BURST, ECHO, HOLDOFF shall be ignored; a trig already high on return to IDLE shall not start a measurement until it falls and rises again.
REQ-025 echo, short_trig, meas_done shall be registered outputs, glitch-free.

Reset
REQ-026 rst_n low shall immediately force state IDLE, echo 0, busy 0, short_trig 0, meas_done 0, all counters and latched distance 0, synchroniser flops 0.
REQ-027 Reset asserted mid-ECHO shall drop echo asynchronously with no meas_done pulse.
REQ-028 After rst_n release, first measurement requires a fresh trig rising edge.

Structure
REQ-029 Package ultrasonic_pkg shall hold the state enum and defaults for CYC_PER_CM, MAX_CM, MAX_ECHO_CYC, TRIG_MIN_CYC, BURST_CYC, HOLDOFF_CYC.
REQ-030 The synchroniser shall be a sub-module bit_sync (2 flops, async active-low reset), reusable for echo capture in the top level.
REQ-031 One shared down-counter (23 bits) shall serve BURST, ECHO and HOLDOFF timing.

Verification
REQ-032 trig high 1000 clks, dist_cm=100 -> echo rises 20000 clks after detected fall, high 583100 clks, one meas_done, busy until holdoff end.
REQ-033 trig high 999 clks -> no echo, single short_trig pulse, FSM in IDLE.
REQ-034 dist_cm=0 and dist_cm=401 -> echo high 3800000 clks each.
REQ-035 second 1000-clk trig during ECHO and during HOLDOFF -> ignored; trig after HOLDOFF_CYC -> new echo produced.
REQ-036 rst_n low 500000 clks into ECHO -> echo 0 same cycle, no meas_done, busy 0; next valid trig served normally.
REQ-037 dist_cm changed 100 -> 10 during BURST -> echo width remains 583100 clks.
